// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a; used by both the TX sequencer and the RX path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int NB_DATA_DFLT    = 8;
  localparam int OVERSAMPLE_DFLT = 16;
  localparam int SB_TICK_DFLT    = 16;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, NB_DATA bits LSB-first, optional parity, stop.
// Latency: start bit on the line the cycle after the accept edge; o_done one cycle after the last stop tick.
// Backpressure: o_ready only in IDLE; i_valid is ignored (not queued) while a frame is in flight.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DFLT,
  parameter int OVERSAMPLE = OVERSAMPLE_DFLT,
  parameter int SB_TICK    = SB_TICK_DFLT,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_done,
  output logic               o_busy
);

  // One tick counter serves both the bit periods and the (possibly longer) stop period.
  localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = $clog2(NB_DATA);

  localparam logic [S_W-1:0] OS_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST  = N_W'(NB_DATA - 1);

  uart_state_e        state_q, state_d;
  logic [S_W-1:0]     s_cnt_q, s_cnt_d;
  logic [N_W-1:0]     n_cnt_q, n_cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  // State and datapath registers; reset parks the line idle-high with no done pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter logic; nothing advances without i_tick except the IDLE accept.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          shift_d = i_data;
          par_d   = (^i_data) ^ (PARITY_ODD != 0);
          s_cnt_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_cnt_q == OS_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_cnt_q == OS_LAST) begin
            shift_d = shift_q >> 1;
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_cnt_d = n_cnt_q + N_W'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      PARITY: begin
        if (i_tick) begin
          if (s_cnt_q == OS_LAST) begin
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_cnt_q == SB_LAST) begin
            s_cnt_d = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so o_tx flips on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_tx    = tx_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four instances (default, even parity, odd parity, 2 stop bits).
// Expected line segments are queued when a word is sent and checked cycle by cycle.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] data;
  logic       vld  [4];
  logic       rdy  [4];
  logic       tx   [4];
  logic       done [4];
  logic       busy [4];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dflt (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_valid(vld[0]), .i_data(data),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_done(done[0]), .o_busy(busy[0]));

  uart_tx_ctrl #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_peven (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_valid(vld[1]), .i_data(data),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_done(done[1]), .o_busy(busy[1]));

  uart_tx_ctrl #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_podd (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_valid(vld[2]), .i_data(data),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_done(done[2]), .o_busy(busy[2]));

  uart_tx_ctrl #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_sb32 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_valid(vld[3]), .i_data(data),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_done(done[3]), .o_busy(busy[3]));

  typedef struct {
    logic lvl;
    int   dur;
  } seg_t;

  seg_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   tick_div    = 1;

  // Advance one clock; all driving and sampling happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick = (cyc % tick_div == 0);
  endtask

  // Expected line segments in clocks for one frame.
  task automatic push_frame(input logic [7:0] d, input int par_en, input int par_odd, input int sb);
    seg_t s;
    s.lvl = 1'b0; s.dur = 16 * tick_div; sb_q.push_back(s);
    for (int i = 0; i < 8; i++) begin
      s.lvl = d[i]; s.dur = 16 * tick_div; sb_q.push_back(s);
    end
    if (par_en != 0) begin
      s.lvl = (^d) ^ (par_odd != 0); s.dur = 16 * tick_div; sb_q.push_back(s);
    end
    s.lvl = 1'b1; s.dur = sb * tick_div; sb_q.push_back(s);
  endtask

  // Present a word; tick phase is aligned so the accept edge carries a tick.
  task automatic send(input int idx, input logic [7:0] d, input bit hold);
    vectors++;
    if (rdy[idx] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_send inst%0d: got %b want 1", idx, rdy[idx]);
    end
    vld[idx] = 1'b1;
    data     = d;
    cyc      = 0;
    tick     = 1'b1;
    step();
    if (!hold) vld[idx] = 1'b0;
  endtask

  // Drain the scoreboard against the line, then check the done pulse.
  task automatic run_frame(input int idx, input string name);
    int   total    = 0;
    int   busy_cnt = 0;
    int   rdy_cnt  = 0;
    int   done_cnt = 0;
    int   seg      = 0;
    seg_t s;
    while (sb_q.size() > 0) begin
      int ok;
      ok = 0;
      s  = sb_q.pop_front();
      for (int c = 0; c < s.dur; c++) begin
        if (tx[idx] === s.lvl) ok++;
        if (busy[idx] === 1'b1) busy_cnt++;
        if (rdy[idx] === 1'b1) rdy_cnt++;
        if (done[idx] === 1'b1) done_cnt++;
        total++;
        step();
      end
      vectors++;
      if (ok !== s.dur) begin
        miscompares++;
        $display("FAIL %s seg%0d: tx at %b for %0d cycles, want %0d", name, seg, s.lvl, ok, s.dur);
      end
      seg++;
    end
    vectors++;
    if (busy_cnt !== total) begin
      miscompares++;
      $display("FAIL %s busy_len: got %0d want %0d", name, busy_cnt, total);
    end
    vectors++;
    if (rdy_cnt !== 0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL %s in_frame: ready cycles %0d done cycles %0d, want 0 and 0", name, rdy_cnt, done_cnt);
    end
    vectors++;
    if (done[idx] !== 1'b1 || rdy[idx] !== 1'b1 || tx[idx] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_cycle: done=%b ready=%b tx=%b want 1 1 1", name, done[idx], rdy[idx], tx[idx]);
    end
    step();
    vectors++;
    if (done[idx] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_width: done=%b one cycle later, want 0", name, done[idx]);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    tick = 1'b1;
    data = 8'h00;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (tx[i] !== 1'b1 || rdy[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset inst%0d: tx=%b ready=%b busy=%b done=%b want 1 1 0 0",
                 i, tx[i], rdy[i], busy[i], done[i]);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    push_frame(8'hA5, 0, 0, 16);
    send(0, 8'hA5, 1'b0);
    run_frame(0, "single_a5");
    repeat (3) step();
  endtask

  task automatic test_slow_tick();
    tick_div = 4;
    push_frame(8'h00, 0, 0, 16);
    send(0, 8'h00, 1'b0);
    run_frame(0, "slow_tick_00");
    tick_div = 1;
    tick     = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_parity();
    push_frame(8'h07, 1, 0, 16);
    send(1, 8'h07, 1'b0);
    run_frame(1, "parity_even_07");
    repeat (3) step();
    push_frame(8'h07, 1, 1, 16);
    send(2, 8'h07, 1'b0);
    run_frame(2, "parity_odd_07");
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    push_frame(8'h55, 0, 0, 16);
    send(0, 8'h55, 1'b1);
    data = 8'h3C;
    run_frame(0, "b2b_first_55");
    vld[0] = 1'b0;
    push_frame(8'h3C, 0, 0, 16);
    run_frame(0, "b2b_second_3c");
    repeat (3) step();
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    done_seen = 0;
    send(0, 8'hA5, 1'b0);
    repeat (16 + 48 + 5) step();
    rst = 1'b1;
    step();
    vectors++;
    if (tx[0] !== 1'b1 || rdy[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: tx=%b ready=%b busy=%b done=%b want 1 1 0 0",
               tx[0], rdy[0], busy[0], done[0]);
    end
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done[0] === 1'b1 || busy[0] === 1'b1) done_seen++;
      step();
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy after reset, want 0", done_seen);
    end
    push_frame(8'h96, 0, 0, 16);
    send(0, 8'h96, 1'b0);
    run_frame(0, "after_reset_96");
    repeat (3) step();
  endtask

  task automatic test_stop_len();
    push_frame(8'hFF, 0, 0, 32);
    send(3, 8'hFF, 1'b0);
    run_frame(3, "stop32_ff");
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_slow_tick();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_stop_len();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- UART transmit sequencer driven by the oversampling tick from the baud rate generator.
- Accepts one data word per valid/ready handshake and serialises it LSB-first as start, data, optional parity and stop.
- Signals completion with a one-cycle pulse.
- Sits between the system-side producer (ALU/interface FSM) and the TX pin. The baud tick is generated externally and shared with the RX path.

Parameters:
- NB_DATA, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, i_tick pulses per start/data/parity bit.
- SB_TICK, 16, i_tick pulses for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  one-cycle baud oversampling pulse.
- i_valid  in  1  producer has a word on i_data.
- i_data  in  NB_DATA  word to transmit.
- o_ready  out  1  block can accept a word.
- o_tx  out  1  serial line, idle high, registered.
- o_done  out  1  one-cycle pulse at end of frame.
- o_busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset (i_clk, i_reset synchronous, active-high): state = IDLE, o_tx = 1, o_ready = 1, o_done = 0, o_busy = 0, tick counter s_cnt = 0, bit counter n_cnt = 0, shift register = 0.
- Reset asserted mid-frame: at the next edge the block returns to IDLE and o_tx = 1. No o_done is generated.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_ready = 1 (combinational from state).
  - An edge with i_valid & o_ready is the accept edge: latch i_data into the shift register, compute the parity bit (XOR of the data, inverted if PARITY_ODD), clear s_cnt, go to START.
  - i_valid is ignored while o_ready = 0. No queuing.
- START: o_tx = 0. s_cnt increments on each i_tick. On i_tick with s_cnt == OVERSAMPLE-1: s_cnt = 0, n_cnt = 0, go to DATA.
- DATA:
  - o_tx = shift[0].
  - On i_tick with s_cnt == OVERSAMPLE-1: shift right, s_cnt = 0.
  - If n_cnt == NB_DATA-1, go to PARITY when PARITY_EN, else STOP. Otherwise increment n_cnt.
- PARITY: o_tx = parity bit. On i_tick with s_cnt == OVERSAMPLE-1: s_cnt = 0, go to STOP.
- STOP: o_tx = 1. On i_tick with s_cnt == SB_TICK-1: go to IDLE and assert o_done for exactly the next cycle.
- o_tx is a registered next-state output, so it changes on the same edge as the state transition.
- Latency: the start bit begins in the cycle after the accept edge. The frame lasts (1 + NB_DATA + PARITY_EN)·OVERSAMPLE + SB_TICK ticks.
- Back-to-back frames: in the o_done cycle the block is already in IDLE with o_ready = 1. A word accepted on that edge starts a new start bit with no extra idle cycle.
- Counter widths:
  - s_cnt = clog2(max(OVERSAMPLE, SB_TICK)) bits.
  - n_cnt = clog2(NB_DATA) bits.
  - Comparisons are exact equality. Counters never wrap past their terminal value.
- i_tick held high continuously is legal (every cycle counts); the bench uses this mode.
- Without i_tick the state and all outputs hold indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, 3 bits);
  - default constants NB_DATA = 8, OVERSAMPLE = 16, SB_TICK = 16.
- The RX block reuses the same package.
- No sub-module: the parity XOR is inline. baud_rate_gen is instantiated beside this block at the UART top, not inside it.

Test Plan:
- Single frame: defaults, i_tick = 1 always, accept 8'hA5. Required:
  - o_tx low for 16 cycles;
  - then bits 1,0,1,0,0,1,0,1, each held 16 cycles;
  - then high for 16 cycles;
  - o_done high exactly one cycle, 160 cycles after the accept edge.
- Realistic tick: tick every 4 clocks, 8'h00. Required: each bit lasts 64 clocks and o_busy stays high for 640 clocks.
- Parity: PARITY_EN = 1, even parity, 8'h07. Required: parity bit = 1 (16 cycles) before the stop bit. With PARITY_ODD = 1 the parity bit = 0. Frame length is 176 ticks.
- Back-to-back: i_valid held high with 8'h55 then 8'h3C. Required: the second start bit begins the cycle after the first o_done with no idle gap. i_valid during the first frame is ignored (o_ready = 0).
- Reset mid-frame: assert i_reset during the DATA state (bit 3). Required:
  - o_tx = 1, o_ready = 1 and o_busy = 0 at the next edge;
  - no o_done;
  - the next accepted frame is transmitted correctly.
- Stop length: SB_TICK = 32, 8'hFF. Required: the line stays high for 32 ticks after the last data bit before o_done.
